butterfly_input_loader: RTL and testbench
=========================================

# butterfly_input_loader

Ping-pong input buffer that sits directly upstream of the fixed-point multi-butterfly in the Pease FFT datapath. It accepts complex samples serially, one per handshake, and collects 2·b samples per frame. It then presents each full frame in parallel as b butterfly operand pairs (a = x[i], b = x[i+b]) on a val/rdy interface. Two banks let the next frame fill while the current frame waits for the butterfly.

## Interface
Parameters:
- n, 32, bit width of each real/imaginary component (two's-complement fixed point, passed through untouched)
- b, 4, butterflies per frame; frame length is 2·b samples; b must be a power of two, b ≥ 1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- recv_val  in  1  input sample valid
- recv_rdy  out  1  loader can accept a sample
- recv_r  in  n  sample real part
- recv_c  in  n  sample imaginary part
- send_val  out  1  full frame presented on outputs
- send_rdy  in  1  downstream butterfly accepts frame
- ar[b], ac[b]  out  n each  first operand of butterfly i = frame sample i
- br[b], bc[b]  out  n each  second operand of butterfly i = frame sample i+b

## Operation
- Storage: two banks of 2·b complex words. Control registers are:
  - wr_bank (1 bit)
  - rd_bank (1 bit)
  - wr_idx (max(1, clog2(2b)) bits)
  - full[1:0]
- Receive fire means recv_val && recv_rdy.
  - The sample is written to bank wr_bank at address addr(wr_idx). Without the macro, addr(wr_idx) = wr_idx.
  - If wr_idx == 2b−1: set full[wr_bank], wr_idx ← 0, toggle wr_bank.
  - Otherwise wr_idx ← wr_idx+1.
- recv_rdy = !full[wr_bank]. It is a function of registers only and has no combinational path from send_rdy.
- send_val = full[rd_bank].
- Outputs are driven combinationally from bank rd_bank:
  - ar[i]/ac[i] = word i
  - br[i]/bc[i] = word i+b
- Send fire means send_val && send_rdy. It clears full[rd_bank] and toggles rd_bank.
- Outputs remain stable while send_val=1 && send_rdy=0. When send_val=0, outputs show the rd_bank contents, which are don't-care to the consumer but deterministic.
- Bank states per bank:
  - FILLING → FULL on the 2b-th write.
  - FULL → EMPTY on send fire.
  - EMPTY equals FILLING once wr_bank points to the bank.
- Both banks full: recv_rdy=0 until a send fire. recv_rdy rises on the cycle after the fire, not the same cycle.
- Simultaneous completing write and send fire: both take effect in the same cycle. They always target different banks, because recv_rdy requires full[wr_bank]=0 and send_val requires full[rd_bank]=1.
- Upstream data values are never modified, truncated or sign-extended.

## Timing
- Reset values:
  - recv_rdy=1, send_val=0
  - all ar/ac/br/bc = 0 (storage cleared)
  - wr_bank=rd_bank=0, wr_idx=0, full=2'b00
- Reset asserted mid-fill or mid-present discards all buffered data. The first accepted sample after reset deasserts is frame sample 0.
- Latency: the last (2b-th) sample accepted at cycle t gives send_val=1 at t+1.
- Throughput: sustains 1 sample/cycle with no recv_rdy bubble, provided each frame is accepted downstream within 2b cycles of becoming valid.
- A frame that is valid and accepted in the same cycle frees its bank at the next edge.

## Configuration
- BUTTERFLY_LOADER_BITREV_EN defined:
  - The write address is the bit-reversal of wr_idx over log2(2b) bits, so frames emerge in bit-reversed order for decimation-in-time staging.
  - For b=1 the reversal is the identity.
- Not defined: natural order, addr = wr_idx.
- Handshake timing is identical in both builds.

## Test plan
- Natural fill: b=4, macro off, feed recv_r = 0..7, recv_c = 100..107, send_rdy=1.
  - Required: send_val one cycle after the 8th sample.
  - ar={0,1,2,3}, br={4,5,6,7}, ac={100..103}, bc={104..107}.
  - Frame accepted in one cycle.
- Bit-reverse: b=4, macro on, feed recv_r = 0..7.
  - Required: ar={0,4,2,6}, br={1,5,3,7}.
- Backpressure: send_rdy=0, recv_val=1 continuously, recv_r = 0..15.
  - recv_rdy falls right after the 16th accept.
  - send_val stays 1 with frame 0 stable.
  - Raise send_rdy for 1 cycle: frame 0 leaves, frame 1 is presented, recv_rdy returns the next cycle.
- Simultaneous events: frame 0 pending with send_rdy=1 on the same cycle frame 1's last sample is accepted.
  - Frame 0 is consumed, frame 1 is valid on the next cycle, and no sample is lost.
- Reset mid-fill: accept 3 samples, pulse reset, then feed 8 samples of value 50..57.
  - Outputs after reset are all 0 with send_val=0.
  - Resulting frame ar={50..53}, br={54..57}.
- b=1 corner: feed 2 samples (7, 9).
  - ar[0]=7, br[0]=9.
  - Continuous streaming gives one frame every 2 cycles.

Source files
------------

// File: rtl/butterfly_input_loader.sv
// butterfly_input_loader: ping-pong input buffer in front of the multi-butterfly.
// Collects 2*b serial complex samples per frame into one of two banks and
// presents a full bank as b parallel operand pairs (a = x[i], b = x[i+b]).
// Optional build macro: BUTTERFLY_LOADER_BITREV_EN stores each frame in
// bit-reversed order (write address = bit-reverse of the sample index).

// Per-lane output select: picks word i and word i+b from the read bank.
module butterfly_input_loader_lane #(
  parameter int n = 32
) (
  input  logic                  sel,
  input  logic [1:0][2*n-1:0]   a_word,
  input  logic [1:0][2*n-1:0]   b_word,
  output logic [n-1:0]          ar,
  output logic [n-1:0]          ac,
  output logic [n-1:0]          br,
  output logic [n-1:0]          bc
);
  assign {ar, ac} = a_word[sel];
  assign {br, bc} = b_word[sel];
endmodule

module butterfly_input_loader #(
  parameter int n = 32,
  parameter int b = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [n-1:0]         recv_r,
  input  logic [n-1:0]         recv_c,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [b-1:0][n-1:0]  ar,
  output logic [b-1:0][n-1:0]  ac,
  output logic [b-1:0][n-1:0]  br,
  output logic [b-1:0][n-1:0]  bc
);
  localparam int FL = 2 * b;
  localparam int IW = ($clog2(FL) < 1) ? 1 : $clog2(FL);
  localparam logic [IW-1:0] LAST = IW'(FL - 1);

  typedef struct packed {
    logic [n-1:0] re;
    logic [n-1:0] im;
  } cplx_t;

  cplx_t [1:0][FL-1:0] mem_q, mem_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IW-1:0]       wr_idx_q, wr_idx_d;
  logic [1:0]          full_q, full_d;
  logic                recv_fire, send_fire;

  // Storage address for the current sample index.
  function automatic logic [IW-1:0] wr_addr(input logic [IW-1:0] idx);
`ifdef BUTTERFLY_LOADER_BITREV_EN
    logic [IW-1:0] r;
    for (int k = 0; k < IW; k++) r[k] = idx[IW-1-k];
    return r;
`else
    return idx;
`endif
  endfunction

  // Handshakes depend only on registered bank state.
  assign recv_rdy  = !full_q[wr_bank_q];
  assign send_val  = full_q[rd_bank_q];
  assign recv_fire = recv_val && recv_rdy;
  assign send_fire = send_val && send_rdy;

  // Next-state: write path fills wr_bank, send path drains rd_bank; the two
  // always touch different banks, so both may act in the same cycle.
  always_comb begin
    mem_d     = mem_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    full_d    = full_q;
    if (recv_fire) begin
      mem_d[wr_bank_q][wr_addr(wr_idx_q)] = '{re: recv_r, im: recv_c};
      if (wr_idx_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_idx_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (send_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // State registers; reset clears storage so outputs come up as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      full_q    <= 2'b00;
    end else begin
      mem_q     <= mem_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
    end
  end

  for (genvar i = 0; i < b; i++) begin : g_lane
    butterfly_input_loader_lane #(.n(n)) u_lane (
      .sel    (rd_bank_q),
      .a_word ({mem_q[1][i],     mem_q[0][i]}),
      .b_word ({mem_q[1][i + b], mem_q[0][i + b]}),
      .ar     (ar[i]),
      .ac     (ac[i]),
      .br     (br[i]),
      .bc     (bc[i])
    );
  end
endmodule

// File: tb/tb_butterfly_input_loader.sv
// Directed bench for butterfly_input_loader: b=4 main instance plus a b=1
// instance. Expected frame layout follows BUTTERFLY_LOADER_BITREV_EN.
module tb_butterfly_input_loader;
  logic clk = 1'b0;
  logic reset;
  logic recv_val, recv_rdy, send_val, send_rdy;
  logic [31:0] recv_r, recv_c;
  logic [3:0][31:0] ar, ac, br, bc;

  logic r1_val, r1_rdy, s1_val, s1_rdy;
  logic [31:0] r1_r, r1_c;
  logic [0:0][31:0] ar1, ac1, br1, bc1;

  int total = 0;
  int bad   = 0;

  // Word index -> frame sample index held at that word.
`ifdef BUTTERFLY_LOADER_BITREV_EN
  int perm [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int perm [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  always #5 clk = ~clk;

  butterfly_input_loader #(.n(32), .b(4)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_r(recv_r), .recv_c(recv_c),
    .send_val(send_val), .send_rdy(send_rdy),
    .ar(ar), .ac(ac), .br(br), .bc(bc)
  );

  butterfly_input_loader #(.n(32), .b(1)) dut1 (
    .clk(clk), .reset(reset),
    .recv_val(r1_val), .recv_rdy(r1_rdy), .recv_r(r1_r), .recv_c(r1_c),
    .send_val(s1_val), .send_rdy(s1_rdy),
    .ar(ar1), .ac(ac1), .br(br1), .bc(bc1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0; r1_val = 1'b0; s1_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input int r, input int c);
    recv_val = 1'b1; recv_r = r; recv_c = c;
    tick();
    recv_val = 1'b0;
  endtask

  task automatic push1(input int r);
    r1_val = 1'b1; r1_r = r; r1_c = r + 1000;
    tick();
    r1_val = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL rst_recv_rdy got=%b exp=1", recv_rdy); end
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL rst_send_val got=%b exp=0", send_val); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({ar[i], ac[i], br[i], bc[i]} !== 128'd0) begin
        bad++; $display("FAIL rst_outputs lane=%0d got=%h exp=0", i, {ar[i], ac[i], br[i], bc[i]});
      end
    end
  endtask

  task automatic test_natural_fill();
    do_reset();
    send_rdy = 1'b1;
    for (int k = 0; k < 7; k++) push(k, 100 + k);
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL fill_early_val got=%b exp=0", send_val); end
    push(7, 107);
    total++; if (send_val !== 1'b1) begin bad++; $display("FAIL fill_latency got=%b exp=1", send_val); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ar[i] !== perm[i] || br[i] !== perm[i+4] ||
          ac[i] !== 100 + perm[i] || bc[i] !== 100 + perm[i+4]) begin
        bad++; $display("FAIL fill_frame lane=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i,
                        ar[i], br[i], ac[i], bc[i], perm[i], perm[i+4], 100 + perm[i], 100 + perm[i+4]);
      end
    end
    tick();
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL fill_consumed got=%b exp=0", send_val); end
    send_rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_bubble k=%0d got=%b exp=1", k, recv_rdy); end
      push(k, 200 + k);
    end
    total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_low got=%b exp=0", recv_rdy); end
    recv_val = 1'b1; recv_r = 99; recv_c = 99;
    for (int w = 0; w < 3; w++) begin
      tick();
      total++;
      if (send_val !== 1'b1 || recv_rdy !== 1'b0 || ar[0] !== perm[0] || br[3] !== perm[7]) begin
        bad++; $display("FAIL bp_hold w=%0d got=val%b rdy%b ar0=%0d br3=%0d exp=val1 rdy0 ar0=%0d br3=%0d",
                        w, send_val, recv_rdy, ar[0], br[3], perm[0], perm[7]);
      end
    end
    send_rdy = 1'b1;
    #1;
    total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_same_cycle got=%b exp=0", recv_rdy); end
    @(negedge clk); // fire edge occurs in between
    @(posedge clk);
    @(negedge clk);
    send_rdy = 1'b0; recv_val = 1'b0;
  endtask

  // Backpressure release checked in its own task with exact edge accounting.
  task automatic test_release();
    do_reset();
    for (int k = 0; k < 16; k++) push(k, 200 + k);
    recv_val = 1'b1; recv_r = 99; recv_c = 99;
    tick();
    send_rdy = 1'b1;
    #1;
    total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL rel_rdy_same_cycle got=%b exp=0", recv_rdy); end
    @(negedge clk);
    send_rdy = 1'b0; recv_val = 1'b0;
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL rel_rdy_next got=%b exp=1", recv_rdy); end
    total++; if (send_val !== 1'b1) begin bad++; $display("FAIL rel_val got=%b exp=1", send_val); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ar[i] !== 8 + perm[i] || br[i] !== 8 + perm[i+4] || ac[i] !== 208 + perm[i]) begin
        bad++; $display("FAIL rel_frame1 lane=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                        ar[i], br[i], ac[i], 8 + perm[i], 8 + perm[i+4], 208 + perm[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 8; k++) push(k, k);
    for (int k = 0; k < 7; k++) push(10 + k, 10 + k);
    total++; if (send_val !== 1'b1 || ar[0] !== perm[0]) begin
      bad++; $display("FAIL sim_pending got=val%b ar0=%0d exp=val1 ar0=%0d", send_val, ar[0], perm[0]);
    end
    send_rdy = 1'b1;
    push(17, 17);
    total++; if (send_val !== 1'b1) begin bad++; $display("FAIL sim_val got=%b exp=1", send_val); end
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL sim_rdy got=%b exp=1", recv_rdy); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ar[i] !== 10 + perm[i] || br[i] !== 10 + perm[i+4]) begin
        bad++; $display("FAIL sim_frame1 lane=%0d got=%0d/%0d exp=%0d/%0d", i,
                        ar[i], br[i], 10 + perm[i], 10 + perm[i+4]);
      end
    end
    tick();
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL sim_drain got=%b exp=0", send_val); end
    send_rdy = 1'b0;
  endtask

  task automatic test_reset_midfill();
    do_reset();
    push(1, 1); push(2, 2); push(3, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
      bad++; $display("FAIL mid_ctrl got=val%b rdy%b exp=val0 rdy1", send_val, recv_rdy);
    end
    total++; if ({ar, ac, br, bc} !== '0) begin
      bad++; $display("FAIL mid_cleared got=%h exp=0", {ar, br});
    end
    for (int k = 0; k < 8; k++) push(50 + k, 60 + k);
    total++; if (send_val !== 1'b1) begin bad++; $display("FAIL mid_val got=%b exp=1", send_val); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ar[i] !== 50 + perm[i] || br[i] !== 50 + perm[i+4] || bc[i] !== 60 + perm[i+4]) begin
        bad++; $display("FAIL mid_frame lane=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                        ar[i], br[i], bc[i], 50 + perm[i], 50 + perm[i+4], 60 + perm[i+4]);
      end
    end
  endtask

  task automatic test_b1();
    do_reset();
    push1(7);
    total++; if (s1_val !== 1'b0) begin bad++; $display("FAIL b1_early got=%b exp=0", s1_val); end
    push1(9);
    total++; if (s1_val !== 1'b1 || ar1[0] !== 32'd7 || br1[0] !== 32'd9 || ac1[0] !== 32'd1007) begin
      bad++; $display("FAIL b1_frame got=val%b ar=%0d br=%0d ac=%0d exp=val1 ar=7 br=9 ac=1007",
                      s1_val, ar1[0], br1[0], ac1[0]);
    end
    s1_rdy = 1'b1;
    for (int j = 0; j < 6; j++) begin
      total++; if (r1_rdy !== 1'b1) begin bad++; $display("FAIL b1_rdy j=%0d got=%b exp=1", j, r1_rdy); end
      push1(20 + j);
      total++;
      if (s1_val !== (j % 2 == 1)) begin
        bad++; $display("FAIL b1_stream_val j=%0d got=%b exp=%b", j, s1_val, (j % 2 == 1));
      end else if (j % 2 == 1 && (ar1[0] !== 20 + j - 1 || br1[0] !== 20 + j)) begin
        bad++; $display("FAIL b1_stream_data j=%0d got=%0d/%0d exp=%0d/%0d", j, ar1[0], br1[0], 20 + j - 1, 20 + j);
      end
    end
    s1_rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0; recv_r = '0; recv_c = '0;
    r1_val = 1'b0; s1_rdy = 1'b0; r1_r = '0; r1_c = '0;
    @(negedge clk);
    test_reset();
    test_natural_fill();
    test_backpressure();
    test_release();
    test_simultaneous();
    test_reset_midfill();
    test_b1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
